cordic_ci_master: RTL and testbench

//  Initiator side of the variable-latency custom-instruction slave protocol
//  (clock/clk_en/start/dataa -> result/done) used by the cordic cosine unit.

---
 rtl/cordic_ci_master_if.sv | 26 ++
 rtl/cordic_ci_master.sv | 125 ++++++++++++
 tb/tb_cordic_ci_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_ci_master_if.sv
// Operand stream, result stream and custom-instruction slave signals of cordic_ci_master.
interface cordic_ci_master_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_timeout;
  logic        ci_aclr;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_result;
  logic        ci_done;

  modport master (
    input  in_valid, in_data, out_ready, ci_result, ci_done,
    output in_ready, out_valid, out_data, out_timeout, ci_aclr, ci_clk_en, ci_start, ci_dataa
  );

  modport slave (
    output in_valid, in_data, out_ready, ci_result, ci_done,
    input  in_ready, out_valid, out_data, out_timeout, ci_aclr, ci_clk_en, ci_start, ci_dataa
  );
endinterface

// File: rtl/cordic_ci_master.sv
// Stream-fed initiator for the variable-latency cordic custom-instruction slave.
// One transaction outstanding; results (or timeout markers) land in a FWFT FIFO.
module cordic_ci_master #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               aclr_n,
  cordic_ci_master_if.master bus,
  output logic [15:0]        txn_count
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     operand_q, operand_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [15:0]     txn_q, txn_d;

  logic [31:0]           fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_to_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic accept, finish, push_to, pop;

  assign accept  = bus.in_valid && bus.in_ready;
  // ci_done is ignored in StIssue: the slave may still show done from the previous op.
  assign finish  = (state_q == StWait) && (bus.ci_done || (timer_q == TmrLast));
  // Done wins over a coincident timeout.
  assign push_to = !bus.ci_done;
  assign pop     = (count_q != '0) && bus.out_ready;

  assign txn_count = txn_q;

  // State and transaction registers.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      state_q   <= StIdle;
      operand_q <= '0;
      timer_q   <= '0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      timer_q   <= timer_d;
      txn_q     <= txn_d;
    end
  end

  // Next-state: IDLE -> ISSUE -> WAIT -> IDLE.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    timer_d   = timer_q;
    txn_d     = txn_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          operand_d = bus.in_data;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (finish) begin
          txn_d   = txn_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs; acceptance only when a FIFO slot is free for the result.
  always_comb begin
    bus.in_ready    = aclr_n && (state_q == StIdle) && (count_q != CntFull);
    bus.ci_start    = (state_q == StIssue);
    bus.ci_clk_en   = (state_q != StIdle);
    bus.ci_dataa    = operand_q;
    bus.ci_aclr     = !aclr_n;
    bus.out_valid   = (count_q != '0);
    bus.out_data    = fifo_data_q[rd_ptr_q];
    bus.out_timeout = fifo_to_q[rd_ptr_q];
  end

  // FIFO pointers, occupancy and timeout flags.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fifo_to_q <= '0;
    end else begin
      if (finish) begin
        fifo_to_q[wr_ptr_q] <= push_to;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (finish && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !finish) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // FIFO payload storage; needs no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (finish) begin
      fifo_data_q[wr_ptr_q] <= push_to ? 32'h0 : bus.ci_result;
    end
  end
endmodule

// File: tb/tb_cordic_ci_master.sv
module tb_cordic_ci_master;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 64;
  localparam logic [31:0] XorKey  = 32'h5A5A_A5A5;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic [15:0] txn_count;

  cordic_ci_master_if bus ();

  cordic_ci_master #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock    (clock),
    .aclr_n   (aclr_n),
    .bus      (bus),
    .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  // Slave model: done level rises d_target clock-enabled cycles after start and stays
  // high (stale) until the next start.
  logic [15:0]  slv_cyc;
  logic [31:0]  slv_res;
  int unsigned  d_target = 17;
  bit           fixed_res = 1'b0;
  bit           force_stale = 1'b0;

  always_ff @(posedge clock) begin
    if (bus.ci_aclr) begin
      slv_cyc <= '0;
      slv_res <= '0;
    end else if (bus.ci_clk_en) begin
      if (bus.ci_start) begin
        slv_cyc <= 16'd1;
        slv_res <= fixed_res ? 32'hDEADBEEF : (bus.ci_dataa ^ XorKey);
      end else if (slv_cyc != 16'd0 && slv_cyc != 16'hFFFF) begin
        slv_cyc <= slv_cyc + 16'd1;
      end
    end
  end

  assign bus.ci_done   = ((slv_cyc != 16'd0) && (32'(slv_cyc) >= d_target)) ||
                         (force_stale && bus.ci_start);
  assign bus.ci_result = slv_res;

  typedef struct packed {
    logic        to;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned exp_txn;
  int          checks = 0;
  int          errors = 0;

  // Reference outcome of one transaction: done arriving within the timeout window
  // yields the slave result, otherwise a zero timeout entry.
  function automatic ent_t model(input logic [31:0] op, input int unsigned d);
    ent_t e;
    if (d > Timeout) begin
      e.to   = 1'b1;
      e.data = 32'h0;
    end else begin
      e.to   = 1'b0;
      e.data = fixed_res ? 32'hDEADBEEF : (op ^ XorKey);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers op; returns sampled in the ISSUE cycle right after the handshake edge.
  task automatic send(input logic [31:0] op, input int unsigned d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = op;
    while (!bus.in_ready && n < 400) begin
      tick();
      n++;
    end
    chk("accept_wait", {31'b0, bus.in_ready}, 32'd1);
    d_target = d;
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(model(op, d));
    exp_txn++;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic pop_check(input string tag);
    int   n;
    ent_t e;
    wait_valid(n);
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_model: observed pop expected no entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, bus.out_data, e.data);
      chk({tag, "_to"}, {31'b0, bus.out_timeout}, {31'b0, e.to});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] op;
    int unsigned d;
    ent_t        head;

    aclr_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    exp_txn       = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_ci_aclr", {31'b0, bus.ci_aclr}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_ci_start", {31'b0, bus.ci_start}, 32'd0);
    chk("rst_ci_clk_en", {31'b0, bus.ci_clk_en}, 32'd0);
    chk("rst_ci_dataa", bus.ci_dataa, 32'h0);
    chk("rst_txn", {16'b0, txn_count}, 32'd0);
    aclr_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("idle_ci_aclr", {31'b0, bus.ci_aclr}, 32'd0);

    // Pop while empty has no effect
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    chk("empty_pop", {31'b0, bus.out_valid}, 32'd0);

    // 1: nominal transaction, 19-cycle latency from handshake
    fixed_res = 1'b1;
    send(32'h3F00_0000, 17);
    chk("t1_start", {31'b0, bus.ci_start}, 32'd1);
    chk("t1_clk_en", {31'b0, bus.ci_clk_en}, 32'd1);
    chk("t1_dataa", bus.ci_dataa, 32'h3F00_0000);
    tick();
    chk("t1_start_pulse", {31'b0, bus.ci_start}, 32'd0);
    chk("t1_dataa_held", bus.ci_dataa, 32'h3F00_0000);
    repeat (16) tick();
    chk("t1_not_yet", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("t1_out_valid", {31'b0, bus.out_valid}, 32'd1);
    pop_check("t1");
    chk("t1_txn", {16'b0, txn_count}, exp_txn);

    // 2: stale done during ISSUE must not be captured
    fixed_res   = 1'b0;
    force_stale = 1'b1;
    send(32'hBF80_0000, 17);
    tick();
    chk("t2_no_issue_capture", {31'b0, bus.out_valid}, 32'd0);
    wait_valid(n);
    chk("t2_latency", n, 32'd17);
    pop_check("t2");
    chk("t2_single_entry", {31'b0, bus.out_valid}, 32'd0);
    force_stale = 1'b0;

    // 3: FIFO full back-pressure, 5th operand waits for one pop
    for (int i = 0; i < 4; i++) begin
      send($urandom, $urandom_range(17, 40));
    end
    op = $urandom;
    bus.in_valid = 1'b1;
    bus.in_data  = op;
    repeat (60) tick();
    chk("t3_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("t3_full_valid", {31'b0, bus.out_valid}, 32'd1);
    pop_check("t3_first");
    send(op, 20);
    for (int i = 0; i < 4; i++) begin
      pop_check("t3_drain");
    end
    chk("t3_empty", {31'b0, bus.out_valid}, 32'd0);
    chk("t3_txn", {16'b0, txn_count}, exp_txn);

    // 4: timeout after 64 WAIT cycles, then done exactly on the last WAIT cycle
    send(32'h4000_0000, 1000);
    wait_valid(n);
    chk("t4_to_latency", n, Timeout + 1);
    chk("t4_idle", {31'b0, bus.ci_clk_en}, 32'd0);
    pop_check("t4_timeout");
    send(32'h4040_0000, Timeout);
    wait_valid(n);
    chk("t4_edge_latency", n, Timeout + 1);
    pop_check("t4_edge");
    chk("t4_txn", {16'b0, txn_count}, exp_txn);

    // 5: reset during WAIT cycle 5 discards the transaction
    send(32'h3F80_0000, 17);
    repeat (5) tick();
    aclr_n = 1'b0;
    #1;
    chk("t5_ci_aclr", {31'b0, bus.ci_aclr}, 32'd1);
    chk("t5_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    aclr_n = 1'b1;
    #1;
    void'(exp_q.pop_back());
    exp_txn = 0;
    chk("t5_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_txn", {16'b0, txn_count}, 32'd0);
    chk("t5_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("t5_clk_en", {31'b0, bus.ci_clk_en}, 32'd0);
    repeat (30) tick();
    chk("t5_no_stale", {31'b0, bus.out_valid}, 32'd0);

    // 6: pop coincides with push of the 4th result
    for (int i = 0; i < 3; i++) begin
      send($urandom, 17);
    end
    send($urandom, 17);
    repeat (17) tick();
    head = exp_q[0];
    chk("t6_head", bus.out_data, head.data);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      pop_check("t6_order");
    end
    chk("t6_count3", {31'b0, bus.out_valid}, 32'd0);
    chk("t6_txn", {16'b0, txn_count}, exp_txn);

    // Random mix of latencies (some timing out) and pops
    for (int i = 0; i < 24; i++) begin
      op = $urandom;
      d  = $urandom_range(17, 72);
      if (exp_q.size() == Depth) begin
        pop_check("rnd_full");
      end
      send(op, d);
      if ($urandom_range(0, 1) == 1) begin
        pop_check("rnd");
      end
    end
    while (exp_q.size() != 0) begin
      pop_check("rnd_drain");
    end
    chk("rnd_empty", {31'b0, bus.out_valid}, 32'd0);
    chk("rnd_txn", {16'b0, txn_count}, exp_txn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
